// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, frame constants, parity helper.
// UART_RX_PARITY_EN adds the PARITY state to the RX encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    RX_IDLE   = ST_IDLE,
    RX_START  = ST_START,
    RX_DATA   = ST_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = ST_PARITY,
`endif
    RX_STOP   = ST_STOP,
    RX_BREAK  = ST_BREAK
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side outputs of the UART receiver; master = receiver, slave = consumer.
interface uart_rx_if
  import uart_pkg::*;
;
  logic [DATA_BITS-1:0] o_data_byte;
  logic                 o_data_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_busy;

  modport master (output o_data_byte, o_data_valid, o_frame_err, o_parity_err, o_busy);
  modport slave  (input  o_data_byte, o_data_valid, o_frame_err, o_parity_err, o_busy);
endinterface

// File: rtl/uart_sync.sv
// Multi-bit 2-flop synchronizer for asynchronous inputs; both stages reset to RST_VAL.
module uart_sync #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) to parallel bytes
// with one-cycle valid / framing-error / parity-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      clk_50M,
  input  logic      i_rst,
  input  logic      i_Rx,
  uart_rx_if.master rx_if
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk_50M),
    .rst (i_rst),
    .d   (i_Rx),
    .q   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_byte_q, data_byte_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_byte_d  = data_byte_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      RX_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        if (!rx_s) begin
          state_d = RX_START;
          busy_d  = 1'b1;
        end
      end
      RX_START: begin
        // Re-check the line at mid start bit so short glitches are rejected.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != even_parity(shift_q));
          state_d   = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (rx_s) begin
            state_d = RX_IDLE;
            busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
              data_byte_d  = shift_q;
              data_valid_d = 1'b1;
            end
`else
            data_byte_d  = shift_q;
            data_valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_BREAK: begin
        // One framing error per low period: hold here until the line idles.
        if (rx_s) begin
          state_d = RX_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = RX_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (i_rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_byte_q  <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.o_data_byte  = data_byte_q;
  assign rx_if.o_data_valid = data_valid_q;
  assign rx_if.o_frame_err  = frame_err_q;
  assign rx_if.o_busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = parity_err_q;
`else
  assign rx_if.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16); honours UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int H    = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int NSTOP = 10;
`else
  localparam bit PAR   = 1'b0;
  localparam int NSTOP = 9;
`endif
  // start edge driven in cycle k -> pulse visible in cycle k + 2 (sync) + 2 + H + NSTOP*CPB
  localparam int PULSE_LAT = 4 + H + NSTOP * CPB;
  localparam int MAXC      = 16384;

  logic clk_50M = 1'b0;
  logic i_rst   = 1'b1;
  logic i_Rx    = 1'b1;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M (clk_50M),
    .i_rst   (i_rst),
    .i_Rx    (i_Rx),
    .rx_if   (rx_if)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Expected per-cycle behaviour, filled in by the frame model ahead of time.
  bit         ev [MAXC];
  logic [7:0] ed [MAXC];
  bit         ef [MAXC];
  bit         ep [MAXC];
  bit         eb [MAXC];
  bit         er [MAXC];

  int         checks = 0;
  int         failures = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mbyte = 8'h00;
  int         last_v_cyc = -1, last_f_cyc = -1;
  logic [7:0] last_v_byte = 8'h00;
  int         v_cnt = 0, f_cnt = 0, p_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_50M) begin
    if (chk_en) begin
      if (er[cyc]) mbyte = 8'h00;
      if (ev[cyc]) mbyte = ed[cyc];
      chk("valid",  32'(rx_if.o_data_valid), 32'(ev[cyc]));
      chk("frame",  32'(rx_if.o_frame_err),  32'(ef[cyc]));
      chk("parity", 32'(rx_if.o_parity_err), 32'(ep[cyc]));
      chk("busy",   32'(rx_if.o_busy),       32'(eb[cyc]));
      chk("byte",   32'(rx_if.o_data_byte),  32'(mbyte));
      if (rx_if.o_data_valid) begin
        last_v_cyc  = cyc;
        last_v_byte = rx_if.o_data_byte;
        v_cnt++;
      end
      if (rx_if.o_frame_err) begin
        last_f_cyc = cyc;
        f_cnt++;
      end
      if (rx_if.o_parity_err) p_cnt++;
    end
  end

  initial begin
    #(64'd20 * (MAXC - 16));
    $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic line(input bit v, input int n);
    i_Rx = v;
    repeat (n) tick();
  endtask

  task automatic mark_busy(input int a, input int b, input bit v);
    for (int c = a; c < b && c < MAXC; c++) eb[c] = v;
  endtask

  task automatic do_reset();
    int j;
    j = cyc;
    i_Rx  = 1'b1;
    i_rst = 1'b1;
    for (int c = j + 1; c < MAXC; c++) begin
      ev[c] = 1'b0; ef[c] = 1'b0; ep[c] = 1'b0; eb[c] = 1'b0;
    end
    er[j + 1] = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  // Drives one frame starting this cycle; abort_at >= 0 resets after that many line cycles.
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop,
                            input int abort_at);
    logic [10:0] w;
    bit          p, good;
    int          k, pc, n;
    k  = cyc;
    pc = k + PULSE_LAT;
    n  = 0;
    p  = (^b) ^ !par_ok;
    w  = '1;
    w[0]   = 1'b0;
    w[8:1] = b;
    if (PAR) begin w[9] = p; w[10] = stop; end
    else     w[9] = stop;
    good  = !PAR || par_ok;
    ev[pc] = stop && good;
    ed[pc] = b;
    ef[pc] = !stop;
    ep[pc] = !good;
    if (stop) mark_busy(k + 3, pc, 1'b1);
    else      mark_busy(k + 3, MAXC, 1'b1);
    for (int i = 0; i < NSTOP + 1; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (n == abort_at) begin
          do_reset();
          return;
        end
        i_Rx = w[i];
        tick();
        n++;
      end
    end
  endtask

  initial begin
    int k, v0, f0, p0, r;
    logic [7:0] rb;
    bit rok;

    repeat (3) tick();
    chk("rst_byte",   32'(rx_if.o_data_byte),  32'h00);
    chk("rst_valid",  32'(rx_if.o_data_valid), 32'h0);
    chk("rst_frame",  32'(rx_if.o_frame_err),  32'h0);
    chk("rst_parity", 32'(rx_if.o_parity_err), 32'h0);
    chk("rst_busy",   32'(rx_if.o_busy),       32'h0);
    i_rst  = 1'b0;
    chk_en = 1'b1;
    line(1'b1, 10);

    // Single ideal frame; pulse cycle pinned by hand (4+7+9*16 or 4+7+10*16).
    k = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    line(1'b1, 8);
    chk("lit_a5_cyc",  32'(last_v_cyc - k), PAR ? 32'd171 : 32'd155);
    chk("lit_a5_byte", 32'(last_v_byte), 32'hA5);

    // Back-to-back frames, no idle gap.
    v0 = v_cnt;
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    line(1'b1, 8);
    chk("lit_b2b_cnt",  32'(v_cnt - v0), 32'd3);
    chk("lit_b2b_last", 32'(last_v_byte), 32'h3C);

    // 4-cycle glitch: false start, no pulses.
    v0 = v_cnt; f0 = f_cnt;
    k = cyc;
    mark_busy(k + 3, k + 4 + H, 1'b1);
    line(1'b0, 4);
    line(1'b1, 20);
    chk("lit_glitch_pulses", 32'((v_cnt - v0) + (f_cnt - f0)), 32'd0);
    chk("lit_glitch_busy",   32'(rx_if.o_busy), 32'd0);

    // Stop bit low then line held low: exactly one framing error, byte kept.
    f0 = f_cnt; v0 = v_cnt;
    k = cyc;
    send_frame(8'h33, 1'b1, 1'b0, -1);
    line(1'b0, 100);
    r = cyc;
    mark_busy(r + 3, MAXC, 1'b0);
    line(1'b1, 20);
    chk("lit_ferr_cnt",  32'(f_cnt - f0), 32'd1);
    chk("lit_ferr_cyc",  32'(last_f_cyc - k), PAR ? 32'd171 : 32'd155);
    chk("lit_ferr_byte", 32'(rx_if.o_data_byte), 32'h3C);
    chk("lit_ferr_nov",  32'(v_cnt - v0), 32'd0);

    // Reset in the middle of data bit 4 (wire bit 5) of 0x5A, then clean 0x81.
    send_frame(8'h5A, 1'b1, 1'b1, 5 * CPB + 8);
    chk("lit_mid_rst_byte", 32'(rx_if.o_data_byte), 32'h00);
    chk("lit_mid_rst_busy", 32'(rx_if.o_busy), 32'd0);
    line(1'b1, 10);
    v0 = v_cnt;
    send_frame(8'h81, 1'b1, 1'b1, -1);
    line(1'b1, 8);
    chk("lit_post_rst_cnt",  32'(v_cnt - v0), 32'd1);
    chk("lit_post_rst_byte", 32'(last_v_byte), 32'h81);

`ifdef UART_RX_PARITY_EN
    p0 = p_cnt; v0 = v_cnt;
    send_frame(8'h07, 1'b0, 1'b1, -1);
    line(1'b1, 8);
    chk("lit_par_bad_perr", 32'(p_cnt - p0), 32'd1);
    chk("lit_par_bad_nov",  32'(v_cnt - v0), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    line(1'b1, 8);
    chk("lit_par_ok_v",    32'(v_cnt - v0), 32'd1);
    chk("lit_par_ok_byte", 32'(last_v_byte), 32'h07);
    chk("lit_par_ok_perr", 32'(p_cnt - p0), 32'd1);
`else
    p0 = p_cnt;
`endif

    // Randomized traffic with random idle gaps (including none).
    for (int i = 0; i < 40; i++) begin
      rb  = 8'($urandom);
      rok = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
      send_frame(rb, rok, 1'b1, -1);
      if ($urandom_range(0, 2) != 0) line(1'b1, $urandom_range(1, 12));
    end
    line(1'b1, 40);
    if (!PAR) chk("lit_no_parity_pulses", 32'(p_cnt - p0), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
